// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the execute stage / multdiv unit and the multdiv sequencer.
// The sequencer takes the slave view; the pipeline side (or a bench) takes the master view.
interface multdiv_sequencer_if;
   logic [31:0] dx_insn;
   logic        dx_valid;
   logic        data_resultRDY;
   logic        data_exception;
   logic [31:0] data_result;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        md_done;
   logic [31:0] md_wdata;
   logic [4:0]  md_rd;
   logic        md_err;

   modport slave (
      input  dx_insn, dx_valid, data_resultRDY, data_exception, data_result,
      output ctrl_MULT, ctrl_DIV, stall, md_done, md_wdata, md_rd, md_err
   );

   modport master (
      output dx_insn, dx_valid, data_resultRDY, data_exception, data_result,
      input  ctrl_MULT, ctrl_DIV, stall, md_done, md_wdata, md_rd, md_err
   );
endinterface

// File: rtl/multdiv_sequencer.sv
// Execute-stage controller for the multi-cycle multdiv unit: issues the start pulse,
// stalls the front of the pipe while the op runs, then presents the writeback for one cycle.
module multdiv_sequencer #(
   parameter int unsigned TIMEOUT      = 40,
   parameter int unsigned MUL_EXC_CODE = 4,
   parameter int unsigned DIV_EXC_CODE = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   multdiv_sequencer_if.slave   mdif
);
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [4:0]  EXC_RD = 5'd30;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            op_div_q, op_div_d;
   logic [4:0]      rd_q, rd_d;
   logic [31:0]     md_wdata_q, md_wdata_d;
   logic [4:0]      md_rd_q, md_rd_d;
   logic            md_err_q, md_err_d;

   logic is_mul, is_div, is_rtype;
   logic unused_insn_bits;

   assign is_rtype = mdif.dx_valid && (mdif.dx_insn[31:27] == 5'b00000);
   assign is_mul   = is_rtype && (mdif.dx_insn[6:2] == 5'b00110);
   assign is_div   = is_rtype && (mdif.dx_insn[6:2] == 5'b00111);
   assign unused_insn_bits = ^{mdif.dx_insn[21:7], mdif.dx_insn[1:0]};

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; memory-free design, so every register is reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_div_q   <= 1'b0;
         rd_q       <= '0;
         md_wdata_q <= '0;
         md_rd_q    <= '0;
         md_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_div_q   <= op_div_d;
         rd_q       <= rd_d;
         md_wdata_q <= md_wdata_d;
         md_rd_q    <= md_rd_d;
         md_err_q   <= md_err_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path infers a latch.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      op_div_d       = op_div_q;
      rd_d           = rd_q;
      md_wdata_d     = md_wdata_q;
      md_rd_d        = md_rd_q;
      md_err_d       = md_err_q;
      mdif.ctrl_MULT = 1'b0;
      mdif.ctrl_DIV  = 1'b0;
      mdif.stall     = 1'b0;
      mdif.md_done   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            mdif.ctrl_MULT = is_mul;
            mdif.ctrl_DIV  = is_div;
            mdif.stall     = is_mul | is_div;
            if (is_mul || is_div) begin
               op_div_d = is_div;
               rd_d     = mdif.dx_insn[26:22];
               cnt_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            mdif.stall = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            // A result arriving on the timeout cycle still counts as a normal completion.
            if (mdif.data_resultRDY) begin
               state_d  = S_DONE;
               md_err_d = 1'b0;
               if (mdif.data_exception) begin
                  md_wdata_d = op_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
                  md_rd_d    = EXC_RD;
               end else begin
                  md_wdata_d = mdif.data_result;
                  md_rd_d    = rd_q;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d    = S_DONE;
               md_err_d   = 1'b1;
               md_wdata_d = op_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
               md_rd_d    = EXC_RD;
            end
         end
         S_DONE: begin
            // The instruction leaves D/X on this edge, so it must not be re-detected.
            mdif.md_done = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // NOTE: the start pulses and stall decode D/X combinationally, so they are
      // gated directly by reset to stay low while reset is held.
      if (reset) begin
         mdif.ctrl_MULT = 1'b0;
         mdif.ctrl_DIV  = 1'b0;
         mdif.stall     = 1'b0;
         mdif.md_done   = 1'b0;
      end
   end

   assign mdif.md_wdata = md_wdata_q;
   assign mdif.md_rd    = md_rd_q;
   assign mdif.md_err   = md_err_q;
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Execute-stage controller for the multi-cycle multiplier/divider unit in the 5-stage pipeline.
- Detects mul/div in the D/X latch and issues a one-cycle start pulse to the multdiv unit.
- Stalls fetch, decode and D/X while the operation runs, then presents the result, or a $rstatus exception write, for the X/M latch.
- Sits beside the execute ALU; the pipeline muxes its result in place of the ALU result.

Parameters:
- TIMEOUT, 40, maximum BUSY cycles before the operation is forced to end with an error.
- MUL_EXC_CODE, 4, value written to $r30 on multiply overflow.
- DIV_EXC_CODE, 5, value written to $r30 on divide exception or timeout of a div.

Ports:
- clock  in  1  master clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dx_insn  in  32  instruction in the D/X latch.
- dx_valid  in  1  D/X holds a real instruction; 0 means bubble.
- data_resultRDY  in  1  multdiv result ready, one-cycle pulse.
- data_exception  in  1  multdiv exception, valid with data_resultRDY.
- data_result  in  32  multdiv result, valid with data_resultRDY.
- ctrl_MULT  out  1  start-multiply pulse.
- ctrl_DIV  out  1  start-divide pulse.
- stall  out  1  hold PC, F/D and D/X; insert a nop into X/M.
- md_done  out  1  result valid this cycle; X/M captures the md_* outputs instead of the ALU.
- md_wdata  out  32  writeback data: product/quotient, or the exception code.
- md_rd  out  5  writeback register: dx_insn[26:22], or 30 on exception.
- md_err  out  1  completion was a timeout.

Behaviour:
- Decode: is_mul = dx_valid & opcode[31:27]==00000 & aluop[6:2]==00110. is_div is the same with aluop 00111. Decode is purely combinational on dx_insn.
- States: IDLE, BUSY, DONE. Encoding is free.
- Reset (async): state IDLE, counter 0. All outputs 0: ctrl_MULT, ctrl_DIV, stall, md_done, md_err, md_wdata, md_rd. A reset mid-operation abandons the op; no pulse or md_done follows.
- IDLE: ctrl_MULT=is_mul, ctrl_DIV=is_div, combinational, same cycle as detection, so operands read straight from D/X. stall=is_mul|is_div. On detection, latch op type and rd, clear the counter, go to BUSY. Otherwise stay.
- BUSY:
  - stall=1; start pulses 0; counter increments each cycle.
  - On data_resultRDY: latch exception, result and op; go to DONE.
  - If the counter reaches TIMEOUT-1 without RDY: set err, treat as exception, go to DONE.
  - If RDY and timeout coincide, RDY wins (err=0).
- DONE: exactly one cycle. stall=0, md_done=1.
  - Normal: md_wdata=result, md_rd=latched rd.
  - Exception: md_wdata=MUL_EXC_CODE or DIV_EXC_CODE by op, md_rd=30.
  - md_err=1 only for a timeout.
  - Next state IDLE. No detection in DONE: the same instruction is leaving D/X this edge, so it must not retrigger.
- md_wdata, md_rd and md_err are registered and hold their last value outside DONE. md_done is 1 only in DONE.
- Latency: issue in cycle N, RDY in cycle N+k, md_done in cycle N+k+1. Total stall is k+1 cycles.
- Back-to-back mul/div: the second is detected in the IDLE cycle after DONE. There is no dead cycle beyond that.
- dx_valid=0 with a mul encoding (flushed slot): no pulse, no stall.
- data_resultRDY while IDLE or DONE: ignored.
- The counter width is enough for TIMEOUT and never wraps; it saturates in IDLE.

Test Plan:
- mul $3,$1,$2 with dx_valid=1; RDY after 17 cycles, result 0x0000_0032.
  - Required: ctrl_MULT high for exactly 1 cycle.
  - Required: stall high for 18 cycles.
  - Required: md_done=1 for 1 cycle with md_rd=3, md_wdata=0x32, md_err=0.
- div $5,$6,$7; RDY with data_exception=1 after 33 cycles.
  - Required: ctrl_DIV pulse.
  - Required: md_done with md_rd=30, md_wdata=5.
- Overflowing mul: RDY with exception → md_rd=30, md_wdata=4.
- Multdiv never returns RDY.
  - Required: exactly 40 BUSY cycles, then md_done with md_err=1, md_rd=30, md_wdata=4 for mul.
  - Then IDLE with stall=0.
- Two consecutive mul instructions, each completing in 5 cycles.
  - Required: two separate pulses.
  - Required: the second pulse comes in the cycle after the first md_done.
  - Required: no duplicate pulse for the first instruction.
- Reset asserted mid-BUSY, off-edge.
  - Required: outputs go to 0 immediately.
  - Required: a late RDY after reset produces no md_done.
  - Required: a mul encoding with dx_valid=0 produces no pulse.
